// File: rtl/jtag_master_pkg.sv
// Shared op codes, FSM state encoding and header-length helper for the JTAG master.
package jtag_master_pkg;

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_IR    = 2'd1;
  localparam logic [1:0] OP_DR    = 2'd2;
  localparam logic [1:0] OP_IDLE  = 2'd3;

  // Five TMS=1 slots reach Test-Logic-Reset from anywhere, one TMS=0 slot lands in RTI.
  localparam int unsigned INIT_SLOTS = 6;

  // StRst is held only while reset is asserted, so outputs show their quiet values.
  typedef enum logic [2:0] {
    StRst,
    StInit,
    StIdle,
    StHdr,
    StShift,
    StTrail,
    StDone
  } state_t;

  // Number of TMS header slots for fixed-length headers (idle op uses its len instead).
  function automatic int unsigned hdr_slots(input logic [1:0] op);
    case (op)
      OP_IR:    hdr_slots = 4;
      OP_DR:    hdr_slots = 3;
      OP_RESET: hdr_slots = 6;
      default:  hdr_slots = 0;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: one bit slot is 2*CLKDIV sysclk cycles, tck high for the last CLKDIV.
module jtag_tck_gen #(
  parameter int unsigned CLKDIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tck,
  output logic o_slot_end,
  output logic o_rise
);

  localparam int unsigned CW = (CLKDIV > 1) ? $clog2(2 * CLKDIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_tck;
  logic          w_wrap;
  logic [CW:0]   w_cnt_nxt;

  assign w_wrap    = (r_cnt == CW'(2 * CLKDIV - 1));
  assign w_cnt_nxt = (CW + 1)'(r_cnt) + 1'b1;

  // Half-period counter; held at zero with tck low whenever the FSM does not need clocks.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_en) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      r_tck <= !w_wrap && (w_cnt_nxt >= (CW + 1)'(CLKDIV));
    end
  end

  assign o_tck      = r_tck;
  // Last cycle of a slot: the FSM advances here so tms/tdi change together with tck falling.
  assign o_slot_end = i_en && w_wrap;
  // tck goes 0->1 on this edge; tdo is sampled on the same edge.
  assign o_rise     = i_en && (r_cnt == CW'(CLKDIV - 1));

endmodule

// File: rtl/jtag_master.sv
// Host-side JTAG initiator: runs TAP reset, IR/DR scans and idle clocks from single commands.
module jtag_master
  import jtag_master_pkg::*;
#(
  parameter int unsigned MAXBITS = 32,
  parameter int unsigned CLKDIV  = 4
) (
  input  logic                         i_sysclk,
  input  logic                         i_reset_n,
  input  logic                         i_cmd_valid,
  output logic                         o_cmd_ready,
  input  logic [1:0]                   i_cmd_op,
  input  logic [$clog2(MAXBITS+1)-1:0] i_cmd_len,
  input  logic [MAXBITS-1:0]           i_cmd_data,
  output logic                         o_rsp_valid,
  output logic [MAXBITS-1:0]           o_rsp_data,
  output logic                         o_busy,
  output logic                         o_tck,
  output logic                         o_tms,
  output logic                         o_tdi,
  input  logic                         i_tdo
);

  localparam int unsigned LW = $clog2(MAXBITS + 1);
  localparam int unsigned IW = (LW > 3) ? LW : 3;

  state_t             r_state, w_state_d;
  logic [IW-1:0]      r_idx;
  logic [1:0]         r_op;
  logic [LW-1:0]      r_len;
  logic [MAXBITS-1:0] r_data, r_mask, r_rsp;

  logic               w_en, w_adv, w_rise, w_accept, w_phase_last;
  logic [LW-1:0]      w_len_clamp;
  logic [IW-1:0]      w_last;

  jtag_tck_gen #(
    .CLKDIV(CLKDIV)
  ) u_tck_gen (
    .i_clk     (i_sysclk),
    .i_rst_n   (i_reset_n),
    .i_en      (w_en),
    .o_tck     (o_tck),
    .o_slot_end(w_adv),
    .o_rise    (w_rise)
  );

  assign w_accept     = (r_state == StIdle) && i_cmd_valid;
  assign w_len_clamp  = (i_cmd_len > LW'(MAXBITS)) ? LW'(MAXBITS) : i_cmd_len;
  assign w_phase_last = w_adv && (r_idx == w_last);

  // Index of the final slot of the current phase.
  always_comb begin
    w_last = '0;
    case (r_state)
      StInit:  w_last = IW'(INIT_SLOTS - 1);
      StHdr:   w_last = (r_op == OP_IDLE) ? IW'(r_len) - IW'(1) : IW'(hdr_slots(r_op) - 1);
      StShift: w_last = IW'(r_len) - IW'(1);
      StTrail: w_last = IW'(1);
      default: w_last = '0;
    endcase
  end

  // State register.
  always_ff @(posedge i_sysclk) begin
    if (!i_reset_n) r_state <= StRst;
    else            r_state <= w_state_d;
  end

  // Next-state logic; zero-length scans and idle ops skip straight to DONE.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StRst:   w_state_d = StInit;
      StInit:  if (w_phase_last) w_state_d = StIdle;
      StIdle: begin
        if (i_cmd_valid) begin
          w_state_d = (i_cmd_op != OP_RESET && w_len_clamp == '0) ? StDone : StHdr;
        end
      end
      StHdr: begin
        if (w_phase_last) w_state_d = (r_op == OP_IR || r_op == OP_DR) ? StShift : StDone;
      end
      StShift: if (w_phase_last) w_state_d = StTrail;
      StTrail: if (w_phase_last) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StRst;
    endcase
  end

  // Command latch, slot index, TDI shifter and TDO capture (one-hot mask selects the bit).
  always_ff @(posedge i_sysclk) begin
    if (!i_reset_n) begin
      r_idx  <= '0;
      r_op   <= OP_RESET;
      r_len  <= '0;
      r_data <= '0;
      r_mask <= '0;
      r_rsp  <= '0;
    end else if (w_accept) begin
      r_idx  <= '0;
      r_op   <= i_cmd_op;
      r_len  <= w_len_clamp;
      r_data <= i_cmd_data;
      r_mask <= MAXBITS'(1);
      r_rsp  <= '0;
    end else begin
      if (w_adv) r_idx <= w_phase_last ? '0 : r_idx + 1'b1;
      if (r_state == StShift && w_rise) r_rsp <= r_rsp | (r_mask & {MAXBITS{i_tdo}});
      if (r_state == StShift && w_adv) begin
        r_data <= r_data >> 1;
        r_mask <= r_mask << 1;
      end
    end
  end

  // Outputs decoded from state and slot index; they only change at slot boundaries.
  always_comb begin
    o_cmd_ready = (r_state == StIdle);
    o_busy      = (r_state != StIdle) && (r_state != StRst);
    o_rsp_valid = (r_state == StDone);
    w_en        = (r_state == StInit) || (r_state == StHdr) ||
                  (r_state == StShift) || (r_state == StTrail);
    o_tdi       = (r_state == StShift) ? r_data[0] : 1'b0;
    o_tms       = 1'b0;
    case (r_state)
      StRst:   o_tms = 1'b1;
      StInit:  o_tms = (r_idx < IW'(INIT_SLOTS - 1));
      StHdr: begin
        case (r_op)
          OP_IR:    o_tms = (r_idx < IW'(2));
          OP_DR:    o_tms = (r_idx == '0);
          OP_RESET: o_tms = (r_idx < IW'(5));
          default:  o_tms = 1'b0;
        endcase
      end
      StShift: o_tms = (r_idx == w_last);
      StTrail: o_tms = (r_idx == '0);
      default: o_tms = 1'b0;
    endcase
  end

  assign o_rsp_data = r_rsp;

endmodule

// File: tb/tb_jtag_master.sv
// Directed bench: two masters (CLKDIV=4 and CLKDIV=1), each driving a behavioural TAP.
module tb_jtag_master;

  localparam int TLR = 0, RTI = 1, SEL_DR = 2, CAP_DR = 3, SH_DR = 4, EX1_DR = 5, PA_DR = 6;
  localparam int EX2_DR = 7, UPD_DR = 8, SEL_IR = 9, CAP_IR = 10, SH_IR = 11, EX1_IR = 12;
  localparam int PA_IR = 13, EX2_IR = 14, UPD_IR = 15;
  localparam logic [31:0] IDCODE = 32'h4111_1043;

  logic        sysclk = 1'b0;
  logic        reset_n;
  logic [1:0]  cmd_valid;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic [1:0]  cmd_ready, rsp_valid, busy, tck, tms, tdi, tdo;
  logic [31:0] rsp_data0, rsp_data1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sysclk = ~sysclk;

  jtag_master #(.MAXBITS(32), .CLKDIV(4)) u_dut0 (
    .i_sysclk(sysclk), .i_reset_n(reset_n), .i_cmd_valid(cmd_valid[0]),
    .o_cmd_ready(cmd_ready[0]), .i_cmd_op(cmd_op), .i_cmd_len(cmd_len),
    .i_cmd_data(cmd_data), .o_rsp_valid(rsp_valid[0]), .o_rsp_data(rsp_data0),
    .o_busy(busy[0]), .o_tck(tck[0]), .o_tms(tms[0]), .o_tdi(tdi[0]), .i_tdo(tdo[0])
  );

  jtag_master #(.MAXBITS(32), .CLKDIV(1)) u_dut1 (
    .i_sysclk(sysclk), .i_reset_n(reset_n), .i_cmd_valid(cmd_valid[1]),
    .o_cmd_ready(cmd_ready[1]), .i_cmd_op(cmd_op), .i_cmd_len(cmd_len),
    .i_cmd_data(cmd_data), .o_rsp_valid(rsp_valid[1]), .o_rsp_data(rsp_data1),
    .o_busy(busy[1]), .o_tck(tck[1]), .o_tms(tms[1]), .o_tdi(tdi[1]), .i_tdo(tdo[1])
  );

  function automatic int tap_next(input int s, input logic m);
    case (s)
      TLR:     tap_next = m ? TLR    : RTI;
      RTI:     tap_next = m ? SEL_DR : RTI;
      SEL_DR:  tap_next = m ? SEL_IR : CAP_DR;
      CAP_DR:  tap_next = m ? EX1_DR : SH_DR;
      SH_DR:   tap_next = m ? EX1_DR : SH_DR;
      EX1_DR:  tap_next = m ? UPD_DR : PA_DR;
      PA_DR:   tap_next = m ? EX2_DR : PA_DR;
      EX2_DR:  tap_next = m ? UPD_DR : SH_DR;
      UPD_DR:  tap_next = m ? SEL_DR : RTI;
      SEL_IR:  tap_next = m ? TLR    : CAP_IR;
      CAP_IR:  tap_next = m ? EX1_IR : SH_IR;
      SH_IR:   tap_next = m ? EX1_IR : SH_IR;
      EX1_IR:  tap_next = m ? UPD_IR : PA_IR;
      PA_IR:   tap_next = m ? EX2_IR : PA_IR;
      EX2_IR:  tap_next = m ? UPD_IR : SH_IR;
      default: tap_next = m ? SEL_DR : RTI;
    endcase
  endfunction

  // Per-master TAP model plus tck/tms/tdi monitors.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int Div = (g == 0) ? 4 : 1;
    int          tap_st   = TLR;
    logic [7:0]  ir       = 8'h00;
    logic [7:0]  ir_sr    = 8'h00;
    logic [31:0] dr       = 32'h0;
    int          rises    = 0;
    int          rsps     = 0;
    int          hi_len   = 0;
    int          hi_bad   = 0;
    int          chg_bad  = 0;
    logic [63:0] tms_hist = 64'h0;
    logic        p_tms    = 1'b1;
    logic        p_tdi    = 1'b0;

    assign tdo[g] = (tap_st == SH_DR) ? dr[0] : (tap_st == SH_IR) ? ir_sr[0] : 1'b0;

    always @(posedge tck[g]) begin
      rises++;
      tms_hist = {tms_hist[62:0], tms[g]};
      case (tap_st)
        CAP_DR:  dr = IDCODE;
        SH_DR:   dr = {tdi[g], dr[31:1]};
        CAP_IR:  ir_sr = 8'h01;
        SH_IR:   ir_sr = {tdi[g], ir_sr[7:1]};
        UPD_IR:  ir = ir_sr;
        TLR:     ir = 8'hFF;
        default: ;
      endcase
      tap_st = tap_next(tap_st, tms[g]);
    end

    always @(posedge sysclk) begin
      if (!reset_n) hi_len = 0;
      else if (tck[g]) hi_len++;
      else if (hi_len != 0) begin
        if (hi_len != Div) hi_bad++;
        hi_len = 0;
      end
      if (tck[g] && (tms[g] != p_tms || tdi[g] != p_tdi)) chg_bad++;
      p_tms = tms[g];
      p_tdi = tdi[g];
      if (rsp_valid[g]) rsps++;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic wait_ready(input logic [1:0] which, input int budget);
    int c;
    c = 0;
    while (((cmd_ready & which) != which) && c < budget) begin
      tick();
      c++;
    end
    check_eq("ready_wait", 64'(cmd_ready & which), 64'(which));
  endtask

  // Issue one command to both masters and collect each response.
  task automatic do_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                        output logic [31:0] r0, output logic [31:0] r1, output int lat0);
    int c;
    bit s0, s1;
    r0 = '0; r1 = '0; lat0 = -1; s0 = 0; s1 = 0;
    wait_ready(2'b11, 500);
    cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 2'b11;
    tick();
    cmd_valid = 2'b00;
    c = 1;
    while (!(s0 && s1) && c < 2000) begin
      if (rsp_valid[0] && !s0) begin s0 = 1; r0 = rsp_data0; lat0 = c; end
      if (rsp_valid[1] && !s1) begin s1 = 1; r1 = rsp_data1; end
      if (!(s0 && s1)) begin tick(); c++; end
    end
    check_eq("cmd_done", 64'({s1, s0}), 64'd3);
    repeat (3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r0, r1;
    int lat, a0, a1, p0, p1, cnt, c;

    reset_n = 1'b0; cmd_valid = 2'b00; cmd_op = 2'd0; cmd_len = '0; cmd_data = '0;
    repeat (3) tick();
    check_eq("rst_tck",   64'(tck),       64'd0);
    check_eq("rst_tms",   64'(tms),       64'd3);
    check_eq("rst_tdi",   64'(tdi),       64'd0);
    check_eq("rst_ready", 64'(cmd_ready), 64'd0);
    check_eq("rst_rspv",  64'(rsp_valid), 64'd0);
    check_eq("rst_busy",  64'(busy),      64'd0);
    check_eq("rst_rspd",  64'({rsp_data1, rsp_data0}), 64'd0);

    // Reset release: INIT sequence.
    a0 = g_mon[0].rises; a1 = g_mon[1].rises;
    reset_n = 1'b1;
    tick();
    check_eq("init_busy", 64'(busy), 64'd3);
    wait_ready(2'b11, 200);
    check_eq("init_rises0", 64'(g_mon[0].rises - a0), 64'd6);
    check_eq("init_rises1", 64'(g_mon[1].rises - a1), 64'd6);
    check_eq("init_tms0",   64'(g_mon[0].tms_hist[5:0]), 64'b111110);
    check_eq("init_tap0",   64'(g_mon[0].tap_st), 64'(RTI));
    check_eq("init_tap1",   64'(g_mon[1].tap_st), 64'(RTI));
    check_eq("init_rsps",   64'(g_mon[0].rsps + g_mon[1].rsps), 64'd0);

    // IR scan 8 bits of 0xE0.
    a0 = g_mon[0].rises; a1 = g_mon[1].rises; p0 = g_mon[0].rsps;
    do_cmd(2'd1, 6'd8, 32'hE0, r0, r1, lat);
    check_eq("ir_rsp0",   64'(r0), 64'h1);
    check_eq("ir_rsp1",   64'(r1), 64'h1);
    check_eq("ir_rises0", 64'(g_mon[0].rises - a0), 64'd14);
    check_eq("ir_rises1", 64'(g_mon[1].rises - a1), 64'd14);
    check_eq("ir_tms0",   64'(g_mon[0].tms_hist[13:0]), 64'b11000000000110);
    check_eq("ir_reg0",   64'(g_mon[0].ir), 64'hE0);
    check_eq("ir_reg1",   64'(g_mon[1].ir), 64'hE0);
    check_eq("ir_pulse",  64'(g_mon[0].rsps - p0), 64'd1);

    // DR scan 32 bits of zero returns IDCODE.
    a0 = g_mon[0].rises; a1 = g_mon[1].rises;
    do_cmd(2'd2, 6'd32, 32'h0, r0, r1, lat);
    check_eq("dr_rsp0",   64'(r0), 64'(IDCODE));
    check_eq("dr_rsp1",   64'(r1), 64'(IDCODE));
    check_eq("dr_rises0", 64'(g_mon[0].rises - a0), 64'd37);
    check_eq("dr_rises1", 64'(g_mon[1].rises - a1), 64'd37);
    check_eq("dr_tap0",   64'(g_mon[0].tap_st), 64'(RTI));

    // DR scan with a pattern: TDI ordering lands in the TAP shift register.
    do_cmd(2'd2, 6'd32, 32'hA5A5_1234, r0, r1, lat);
    check_eq("drp_tdi0", 64'(g_mon[0].dr), 64'hA5A5_1234);
    check_eq("drp_tdi1", 64'(g_mon[1].dr), 64'hA5A5_1234);
    check_eq("drp_rsp0", 64'(r0), 64'(IDCODE));

    // Zero-length DR scan.
    a0 = g_mon[0].rises; a1 = g_mon[1].rises;
    do_cmd(2'd2, 6'd0, 32'hFFFF_FFFF, r0, r1, lat);
    check_eq("dr0_lat",   64'(lat), 64'd1);
    check_eq("dr0_rsp0",  64'(r0), 64'd0);
    check_eq("dr0_rises", 64'((g_mon[0].rises - a0) + (g_mon[1].rises - a1)), 64'd0);

    // Length 40 clamps to 32 shift slots.
    a0 = g_mon[0].rises;
    do_cmd(2'd2, 6'd40, 32'h0, r0, r1, lat);
    check_eq("dr40_rises", 64'(g_mon[0].rises - a0), 64'd37);
    check_eq("dr40_rsp0",  64'(r0), 64'(IDCODE));

    // TAP reset op: six slots, zero response.
    a0 = g_mon[0].rises;
    do_cmd(2'd0, 6'd0, 32'h0, r0, r1, lat);
    check_eq("rst_op_rises", 64'(g_mon[0].rises - a0), 64'd6);
    check_eq("rst_op_rsp",   64'({r1, r0}), 64'd0);
    check_eq("rst_op_tap",   64'(g_mon[0].tap_st), 64'(RTI));

    // Idle op: len slots of TMS=0.
    a0 = g_mon[0].rises; a1 = g_mon[1].rises;
    do_cmd(2'd3, 6'd5, 32'hFFFF_FFFF, r0, r1, lat);
    check_eq("idle_rises0", 64'(g_mon[0].rises - a0), 64'd5);
    check_eq("idle_rises1", 64'(g_mon[1].rises - a1), 64'd5);
    check_eq("idle_tms",    64'(g_mon[0].tms_hist[4:0]), 64'd0);
    check_eq("idle_rsp",    64'(r0), 64'd0);

    // cmd_valid held high on master 0 across two DR scans.
    wait_ready(2'b01, 500);
    a0 = g_mon[0].rises; p0 = g_mon[0].rsps; cnt = 0; c = 0;
    cmd_op = 2'd2; cmd_len = 6'd32; cmd_data = 32'h0; cmd_valid = 2'b01;
    while (cnt < 2 && c < 3000) begin
      tick();
      c++;
      if (rsp_valid[0]) begin
        cnt++;
        check_eq("held_rsp", 64'(rsp_data0), 64'(IDCODE));
      end
    end
    cmd_valid = 2'b00;
    repeat (3) tick();
    check_eq("held_cnt",   64'(cnt), 64'd2);
    check_eq("held_pulse", 64'(g_mon[0].rsps - p0), 64'd2);
    check_eq("held_rises", 64'(g_mon[0].rises - a0), 64'd74);

    // Reset for one cycle in the middle of a DR shift.
    wait_ready(2'b01, 500);
    p0 = g_mon[0].rsps;
    cmd_op = 2'd2; cmd_len = 6'd32; cmd_data = 32'h0; cmd_valid = 2'b01;
    tick();
    cmd_valid = 2'b00;
    a0 = g_mon[0].rises; c = 0;
    while ((g_mon[0].rises - a0) < 10 && c < 1000) begin tick(); c++; end
    check_eq("abort_inshift", 64'(busy[0]), 64'd1);
    reset_n = 1'b0;
    tick();
    check_eq("abort_tck",   64'(tck[0]),       64'd0);
    check_eq("abort_tms",   64'(tms[0]),       64'd1);
    check_eq("abort_tdi",   64'(tdi[0]),       64'd0);
    check_eq("abort_ready", 64'(cmd_ready[0]), 64'd0);
    check_eq("abort_busy",  64'(busy[0]),      64'd0);
    check_eq("abort_rspd",  64'(rsp_data0),    64'd0);
    a0 = g_mon[0].rises; a1 = g_mon[1].rises;
    reset_n = 1'b1;
    wait_ready(2'b11, 200);
    repeat (3) tick();
    check_eq("abort_rises0", 64'(g_mon[0].rises - a0), 64'd6);
    check_eq("abort_rises1", 64'(g_mon[1].rises - a1), 64'd6);
    check_eq("abort_norsp",  64'(g_mon[0].rsps - p0), 64'd0);
    check_eq("abort_tap",    64'(g_mon[0].tap_st), 64'(RTI));

    // Timing invariants collected over the whole run.
    check_eq("tck_high0", 64'(g_mon[0].hi_bad),  64'd0);
    check_eq("tck_high1", 64'(g_mon[1].hi_bad),  64'd0);
    check_eq("stable0",   64'(g_mon[0].chg_bad), 64'd0);
    check_eq("stable1",   64'(g_mon[1].chg_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
